bcd_countdown_timer: RTL and testbench



---
 rtl/bcd_countdown_timer.sv | 238 +++++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: DIGITS-wide BCD preset/countdown timer with synchronised
// keys and a multiplexed 7-segment scan driver.
// Build macro LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 never blanked).
module bcd_countdown_timer #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_inc1,
    input  logic                  btn_inc10,
    input  logic                  btn_start,
    input  logic                  btn_clear,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     cat,
    output logic [4*DIGITS-1:0]   value,
    output logic                  running,
    output logic                  done
);

    localparam int unsigned VAL_W   = 4 * DIGITS;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned K_INC1  = 0;
    localparam int unsigned K_INC10 = 1;
    localparam int unsigned K_START = 2;
    localparam int unsigned K_CLEAR = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // BCD increment starting at digit 'first', carry rippling upward, wraps at all-nines
    function automatic logic [VAL_W-1:0] bcd_inc(input logic [VAL_W-1:0] v, input int unsigned first);
        logic [VAL_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((i >= first) && carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement by one with borrow
    function automatic logic [VAL_W-1:0] bcd_dec(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Segment pattern, bit0=a .. bit6=g, dp off
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    logic [3:0]        sync1_q, sync2_q, hist_q, ev_q;
    state_t            state_q, state_d;
    logic [VAL_W-1:0]  value_q, value_d, dec_c;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              running_q, done_q, done_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] cat_q, cat_d;
    logic [3:0]        digit_c;
    logic              blank_c;

    // Key synchronisers, history and registered rising-edge events
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            ev_q    <= '0;
        end else begin
            sync1_q <= {btn_clear, btn_start, btn_inc10, btn_inc1};
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            ev_q    <= sync2_q & ~hist_q;
        end
    end

    // Control state, preset value and tick counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            value_q   <= '0;
            tick_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            tick_q    <= tick_d;
            running_q <= (state_d == S_RUN);
            done_q    <= done_d;
        end
    end

    // Next state: clear beats start beats inc10 beats inc1; losers are dropped
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        dec_c   = bcd_dec(value_q);
        if (ev_q[K_CLEAR]) begin
            state_d = S_IDLE;
            value_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_q[K_START]) begin
                        if (value_q != '0) begin
                            state_d = S_RUN;
                            tick_d  = '0;
                        end
                    end else if (ev_q[K_INC10]) begin
                        value_d = bcd_inc(value_q, 1);
                    end else if (ev_q[K_INC1]) begin
                        value_d = bcd_inc(value_q, 0);
                    end
                end
                S_RUN: begin
                    if (ev_q[K_START]) begin
                        state_d = S_PAUSE;
                    end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                        tick_d  = '0;
                        value_d = dec_c;
                        if (dec_c == '0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (ev_q[K_START]) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Scan index/prescaler advance and segment/select generation for current digit
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        digit_c = 4'd0;
        blank_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                digit_c = value_q[4*i +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        blank_c = (idx_q != '0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_q) && (value_q[4*i +: 4] != 4'd0)) begin
                blank_c = 1'b0;
            end
        end
`else
        blank_c = 1'b0;
`endif
        seg_d = blank_c ? 8'h00 : seg_decode(digit_c);
        cat_d = ~(DIGITS'(1) << idx_q);
    end

    // Scan registers and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 8'h00;
            cat_q      <= '1;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            cat_q      <= cat_d;
        end
    end

    assign seg     = seg_q;
    assign cat     = cat_q;
    assign value   = value_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer at DIGITS=2, TICK_DIV=10, SCAN_DIV=4.
module tb_bcd_countdown_timer;

    localparam int unsigned DIGITS   = 2;
    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned SCAN_DIV = 4;

    localparam logic [3:0] K_INC1  = 4'b0001;
    localparam logic [3:0] K_INC10 = 4'b0010;
    localparam logic [3:0] K_START = 4'b0100;
    localparam logic [3:0] K_CLEAR = 4'b1000;

    typedef struct packed {
        logic [7:0] value;
        logic       running;
        logic       done;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                btn_inc1 = 1'b0;
    logic                btn_inc10 = 1'b0;
    logic                btn_start = 1'b0;
    logic                btn_clear = 1'b0;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   cat;
    logic [4*DIGITS-1:0] value;
    logic                running;
    logic                done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_v  = 0;
    exp_t sb[$];
    logic [1:0] cat_sb[$];
    logic [7:0] seg_sb[$];
    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    bcd_countdown_timer #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_inc1  (btn_inc1),
        .btn_inc10 (btn_inc10),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .seg       (seg),
        .cat       (cat),
        .value     (value),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] m);
        {btn_clear, btn_start, btn_inc10, btn_inc1} = m;
    endtask

    // Raise keys; return just after the edge where the event takes effect
    task automatic key_down(input logic [3:0] m);
        set_keys(m);
        repeat (4) step();
    endtask

    task automatic key_up();
        set_keys(4'b0000);
        repeat (3) step();
    endtask

    task automatic preset_to(input int v);
        key_down(K_CLEAR);
        key_up();
        for (int i = 0; i < v / 10; i++) begin
            key_down(K_INC10);
            key_up();
        end
        for (int i = 0; i < v % 10; i++) begin
            key_down(K_INC1);
            key_up();
        end
        model_v = v;
    endtask

    task automatic test_reset();
        logic [1:0] ec;
        logic [7:0] es;
        rst = 1'b1;
        set_keys(4'b0000);
        repeat (3) step();
        n_checks += 5;
        if (seg !== 8'h00) begin n_fail++; $display("FAIL reset_seg: got %h expected 00", seg); end
        if (cat !== 2'b11) begin n_fail++; $display("FAIL reset_cat: got %b expected 11", cat); end
        if (value !== 8'h00) begin n_fail++; $display("FAIL reset_value: got %h expected 00", value); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            cat_sb.push_back(((k / SCAN_DIV) % 2 == 0) ? 2'b10 : 2'b01);
`ifdef LEADING_ZERO_BLANK_EN
            seg_sb.push_back(((k / SCAN_DIV) % 2 == 0) ? 8'h3F : 8'h00);
`else
            seg_sb.push_back(8'h3F);
`endif
        end
        rst = 1'b0;
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            step();
            ec = cat_sb.pop_front();
            es = seg_sb.pop_front();
            n_checks += 3;
            if (cat !== ec) begin n_fail++; $display("FAIL scan_cat k=%0d: got %b expected %b", k, cat, ec); end
            if (seg !== es) begin n_fail++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, es); end
            if (running !== 1'b0) begin n_fail++; $display("FAIL scan_running k=%0d: got %b expected 0", k, running); end
        end
    endtask

    task automatic test_preset();
        logic [3:0] seq[$];
        exp_t e;
        for (int i = 0; i < 9; i++) seq.push_back(K_INC10);
        for (int i = 0; i < 10; i++) seq.push_back(K_INC1);
        for (int i = 0; i < 9; i++) seq.push_back(K_INC10);
        for (int i = 0; i < 5; i++) seq.push_back(K_INC1);
        seq.push_back(K_INC10);
        foreach (seq[j]) begin
            model_v = (seq[j] == K_INC10) ? (model_v + 10) % 100 : (model_v + 1) % 100;
            sb.push_back('{value: bcd8(model_v), running: 1'b0, done: 1'b0});
            key_down(seq[j]);
            e = sb.pop_front();
            n_checks += 1;
            if (value !== e.value) begin n_fail++; $display("FAIL preset_value step=%0d: got %h expected %h", j, value, e.value); end
            repeat (3) step();
            n_checks += 1;
            if (value !== e.value) begin n_fail++; $display("FAIL preset_held step=%0d: got %h expected %h", j, value, e.value); end
            key_up();
        end
    endtask

    task automatic test_countdown();
        exp_t e;
        int   v;
        preset_to(3);
        key_down(K_START);
        set_keys(4'b0000);
        n_checks += 2;
        if (running !== 1'b1) begin n_fail++; $display("FAIL cd_start_running: got %b expected 1", running); end
        if (value !== 8'h03) begin n_fail++; $display("FAIL cd_start_value: got %h expected 03", value); end
        for (int k = 1; k <= 35; k++) begin
            v = 3 - k / TICK_DIV;
            if (v < 0) v = 0;
            sb.push_back('{value: bcd8(v), running: (k < 30), done: (k == 30)});
        end
        for (int k = 1; k <= 35; k++) begin
            step();
            e = sb.pop_front();
            n_checks += 3;
            if (value !== e.value) begin n_fail++; $display("FAIL cd_value k=%0d: got %h expected %h", k, value, e.value); end
            if (running !== e.running) begin n_fail++; $display("FAIL cd_running k=%0d: got %b expected %b", k, running, e.running); end
            if (done !== e.done) begin n_fail++; $display("FAIL cd_done k=%0d: got %b expected %b", k, done, e.done); end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        preset_to(5);
        key_down(K_START);
        set_keys(4'b0000);
        repeat (22) step();
        key_down(K_START);
        set_keys(4'b0000);
        n_checks += 2;
        if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b expected 0", running); end
        if (value !== 8'h03) begin n_fail++; $display("FAIL pause_value: got %h expected 03", value); end
        for (int k = 0; k < 100; k++) sb.push_back('{value: 8'h03, running: 1'b0, done: 1'b0});
        for (int k = 0; k < 100; k++) begin
            step();
            e = sb.pop_front();
            n_checks += 2;
            if (value !== e.value) begin n_fail++; $display("FAIL paused_value k=%0d: got %h expected %h", k, value, e.value); end
            if (done !== e.done) begin n_fail++; $display("FAIL paused_done k=%0d: got %b expected %b", k, done, e.done); end
        end
        key_down(K_START);
        set_keys(4'b0000);
        n_checks += 1;
        if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b expected 1", running); end
        for (int k = 1; k <= 6; k++) sb.push_back('{value: (k < 5) ? 8'h03 : 8'h02, running: 1'b1, done: 1'b0});
        for (int k = 1; k <= 6; k++) begin
            step();
            e = sb.pop_front();
            n_checks += 2;
            if (value !== e.value) begin n_fail++; $display("FAIL resume_value k=%0d: got %h expected %h", k, value, e.value); end
            if (running !== e.running) begin n_fail++; $display("FAIL resume_running k=%0d: got %b expected %b", k, running, e.running); end
        end
    endtask

    task automatic test_collide();
        exp_t e;
        preset_to(0);
        key_down(K_START | K_INC1);
        n_checks += 2;
        if (value !== 8'h00) begin n_fail++; $display("FAIL start_inc1_value: got %h expected 00", value); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL start_inc1_running: got %b expected 0", running); end
        key_up();
        n_checks += 1;
        if (value !== 8'h00) begin n_fail++; $display("FAIL start_inc1_after: got %h expected 00", value); end
        preset_to(2);
        key_down(K_START);
        set_keys(4'b0000);
        repeat (2) step();
        key_down(K_CLEAR | K_START);
        set_keys(4'b0000);
        n_checks += 3;
        if (value !== 8'h00) begin n_fail++; $display("FAIL clear_start_value: got %h expected 00", value); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL clear_start_running: got %b expected 0", running); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL clear_start_done: got %b expected 0", done); end
        for (int k = 0; k < 15; k++) sb.push_back('{value: 8'h00, running: 1'b0, done: 1'b0});
        for (int k = 0; k < 15; k++) begin
            step();
            e = sb.pop_front();
            n_checks += 3;
            if (value !== e.value) begin n_fail++; $display("FAIL cleared_value k=%0d: got %h expected %h", k, value, e.value); end
            if (running !== e.running) begin n_fail++; $display("FAIL cleared_running k=%0d: got %b expected %b", k, running, e.running); end
            if (done !== e.done) begin n_fail++; $display("FAIL cleared_done k=%0d: got %b expected %b", k, done, e.done); end
        end
    endtask

    task automatic test_reset_midrun();
        preset_to(2);
        key_down(K_START);
        set_keys(4'b0000);
        repeat (5) step();
        n_checks += 1;
        if (running !== 1'b1) begin n_fail++; $display("FAIL midrun_running: got %b expected 1", running); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks += 5;
        if (value !== 8'h00) begin n_fail++; $display("FAIL midrun_rst_value: got %h expected 00", value); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_running: got %b expected 0", running); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_done: got %b expected 0", done); end
        if (seg !== 8'h00) begin n_fail++; $display("FAIL midrun_rst_seg: got %h expected 00", seg); end
        if (cat !== 2'b11) begin n_fail++; $display("FAIL midrun_rst_cat: got %b expected 11", cat); end
        step();
        n_checks += 2;
        if (cat !== 2'b10) begin n_fail++; $display("FAIL post_rst_cat: got %b expected 10", cat); end
        if (seg !== seg_tab[0]) begin n_fail++; $display("FAIL post_rst_seg: got %h expected %h", seg, seg_tab[0]); end
    endtask

    task automatic test_display();
        logic [7:0] exp_hi;
        preset_to(7);
`ifdef LEADING_ZERO_BLANK_EN
        exp_hi = 8'h00;
`else
        exp_hi = seg_tab[0];
`endif
        for (int i = 0; i < 4 * SCAN_DIV && cat !== 2'b10; i++) step();
        n_checks += 2;
        if (cat !== 2'b10) begin n_fail++; $display("FAIL disp_wait_d0: got %b expected 10", cat); end
        if (seg !== seg_tab[7]) begin n_fail++; $display("FAIL disp_d0_seg: got %h expected %h", seg, seg_tab[7]); end
        for (int i = 0; i < 4 * SCAN_DIV && cat !== 2'b01; i++) step();
        n_checks += 2;
        if (cat !== 2'b01) begin n_fail++; $display("FAIL disp_wait_d1: got %b expected 01", cat); end
        if (seg !== exp_hi) begin n_fail++; $display("FAIL disp_d1_seg: got %h expected %h", seg, exp_hi); end
    endtask

    initial begin
        test_reset();
        test_preset();
        test_countdown();
        test_pause();
        test_collide();
        test_reset_midrun();
        test_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
